// File: rtl/wb_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the Wishbone SDRAM arbiter:
//   arb_state_e  - arbiter FSM states (IDLE, GRANT, ABORT)
//   rr_next()    - round-robin scan helper. It returns the first requester found
//                  when scanning last+1, last+2, ... (mod n). It works on a vector
//                  sized to the largest supported master count, so any block can
//                  reuse it by zero-extending its request vector.
// -----------------------------------------------------------------------------
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ABORT = 2'd2
   } arb_state_e;

   localparam int MAX_MASTERS = 8;

   // Returns the index of the first set bit of req, scanning from last+1 with
   // wrap-around over n requesters. Returns 0 when req has no bit set; callers
   // qualify the result with |req.
   function automatic logic [2:0] rr_next(input logic [7:0] req,
                                          input logic [2:0] last,
                                          input int         n);
      logic [2:0] pick;
      logic       found;
      logic [2:0] cand;
      pick  = 3'd0;
      found = 1'b0;
      for (int i = 1; i <= MAX_MASTERS; i++) begin
         cand = 3'((int'(last) + i) % n);
         if ((i <= n) && !found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end else begin
            pick  = pick;
            found = found;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker.
// Ports:
//   req   in  N       request vector, one bit per master
//   last  in  GW      index of the master served most recently
//   idx   out GW      selected master (first requester after last, wrapping)
//   valid out 1       at least one request is present
// -----------------------------------------------------------------------------
module rr_pick
   import wb_arb_pkg::*;
#(
   parameter int N  = 3,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last,
   output logic [GW-1:0] idx,
   output logic          valid
);

   logic [2:0] pick;

   // Scan the requests starting just after the last served master.
   always_comb begin
      pick  = rr_next(8'(req), 3'(last), N);
      idx   = GW'(pick);
      valid = |req;
   end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_sdram_arbiter
// Round-robin Wishbone arbiter that shares one cached SDRAM controller slave port
// among NMASTERS requesters. A grant is held for a whole bus cycle (cyc); a
// watchdog aborts cycles that the slave never acknowledges.
// Ports:
//   clk_i    in   1              system clock
//   rst_i    in   1              asynchronous reset, active low
//   m_cyc_i  in   NMASTERS       per-master cycle request
//   m_stb_i  in   NMASTERS       per-master strobe
//   m_we_i   in   NMASTERS       per-master write enable
//   m_sel_i  in   NMASTERS*DW/8  per-master byte selects, master k at [k*DW/8 +: DW/8]
//   m_adr_i  in   NMASTERS*AW    per-master address, master k at [k*AW +: AW]
//   m_dat_i  in   NMASTERS*DW    per-master write data, master k at [k*DW +: DW]
//   m_dat_o  out  DW             read data, broadcast to all masters
//   m_ack_o  out  NMASTERS       ack, granted master only
//   m_err_o  out  NMASTERS       one-cycle error pulse on watchdog abort
//   s_cyc_o  out  1              to cache: cycle
//   s_stb_o  out  1              to cache: strobe
//   s_we_o   out  1              to cache: write enable
//   s_sel_o  out  DW/8           to cache: byte selects
//   s_adr_o  out  AW             to cache: address
//   s_dat_o  out  DW             to cache: write data
//   s_dat_i  in   DW             from cache: read data
//   s_ack_i  in   1              from cache: ack
//   grant_o  out  clog2(NMASTERS) current / last granted master index
//   busy_o   out  1              arbiter not idle
// -----------------------------------------------------------------------------
module wb_sdram_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NMASTERS = 3,
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int TIMEOUT  = 1024
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NMASTERS-1:0]          m_cyc_i,
   input  logic [NMASTERS-1:0]          m_stb_i,
   input  logic [NMASTERS-1:0]          m_we_i,
   input  logic [NMASTERS*(DW/8)-1:0]   m_sel_i,
   input  logic [NMASTERS*AW-1:0]       m_adr_i,
   input  logic [NMASTERS*DW-1:0]       m_dat_i,
   output logic [DW-1:0]                m_dat_o,
   output logic [NMASTERS-1:0]          m_ack_o,
   output logic [NMASTERS-1:0]          m_err_o,
   output logic                         s_cyc_o,
   output logic                         s_stb_o,
   output logic                         s_we_o,
   output logic [DW/8-1:0]              s_sel_o,
   output logic [AW-1:0]                s_adr_o,
   output logic [DW-1:0]                s_dat_o,
   input  logic [DW-1:0]                s_dat_i,
   input  logic                         s_ack_i,
   output logic [$clog2(NMASTERS)-1:0]  grant_o,
   output logic                         busy_o
);

   localparam int GW  = $clog2(NMASTERS);
   localparam int SW  = DW / 8;
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Watchdog value on which an un-acked strobe is aborted.
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   arb_state_e          state, state_next;
   logic [GW-1:0]       grant, grant_next;
   logic [GW-1:0]       last, last_next;
   logic [WDW-1:0]      wdog, wdog_next;
   logic [NMASTERS-1:0] err, err_next;
   logic [GW-1:0]       pick_idx;
   logic                pick_valid;
   logic                timeout_hit;

   logic [AW-1:0]       adr_arr [NMASTERS];
   logic [DW-1:0]       dat_arr [NMASTERS];
   logic [SW-1:0]       sel_arr [NMASTERS];

   rr_pick #(
      .N  (NMASTERS),
      .GW (GW)
   ) u_pick (
      .req   (m_cyc_i),
      .last  (last),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Unpack the per-master buses so the grant index can select them directly.
   always_comb begin
      for (int k = 0; k < NMASTERS; k++) begin
         adr_arr[k] = m_adr_i[k*AW +: AW];
         dat_arr[k] = m_dat_i[k*DW +: DW];
         sel_arr[k] = m_sel_i[k*SW +: SW];
      end
   end

   // Timeout fires only on a live, un-acked strobe that has waited TIMEOUT cycles;
   // an ack arriving on that same cycle takes precedence.
   always_comb begin
      timeout_hit = (TIMEOUT > 0) && (state == GRANT) && s_stb_o && !s_ack_i
                    && (wdog == WD_LAST);
   end

   // Next-state, grant/last bookkeeping and error pulse generation.
   always_comb begin
      state_next = state;
      grant_next = grant;
      last_next  = last;
      err_next   = {NMASTERS{1'b0}};
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_next = GRANT;
               grant_next = pick_idx;
            end else begin
               state_next = IDLE;
            end
         end
         GRANT: begin
            // Master ending its cycle takes priority over a coincident timeout.
            if (!m_cyc_i[grant]) begin
               state_next = IDLE;
               last_next  = grant;
            end else if (timeout_hit) begin
               state_next      = ABORT;
               err_next[grant] = 1'b1;
            end else begin
               state_next = GRANT;
            end
         end
         ABORT: begin
            if (!m_cyc_i[grant]) begin
               state_next = IDLE;
               last_next  = grant;
            end else begin
               state_next = ABORT;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Watchdog counts consecutive un-acked strobe cycles.
   always_comb begin
      if (TIMEOUT == 0) begin
         wdog_next = {WDW{1'b0}};
      end else if (s_ack_i || !s_stb_o || timeout_hit) begin
         wdog_next = {WDW{1'b0}};
      end else begin
         wdog_next = wdog + {{(WDW-1){1'b0}}, 1'b1};
      end
   end

   // State, grant, round-robin pointer, watchdog and error registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         grant <= {GW{1'b0}};
         last  <= GW'(NMASTERS - 1);
         wdog  <= {WDW{1'b0}};
         err   <= {NMASTERS{1'b0}};
      end else begin
         state <= state_next;
         grant <= grant_next;
         last  <= last_next;
         wdog  <= wdog_next;
         err   <= err_next;
      end
   end

   // Slave-side mux and ack routing. The mux follows the granted master live,
   // so s_cyc_o drops in the same cycle the master releases m_cyc_i.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = {SW{1'b0}};
      s_adr_o = {AW{1'b0}};
      s_dat_o = {DW{1'b0}};
      m_ack_o = {NMASTERS{1'b0}};
      m_dat_o = s_dat_i;
      if (state == GRANT) begin
         s_cyc_o        = m_cyc_i[grant];
         s_stb_o        = m_stb_i[grant];
         s_we_o         = m_we_i[grant];
         s_sel_o        = sel_arr[grant];
         s_adr_o        = adr_arr[grant];
         s_dat_o        = dat_arr[grant];
         m_ack_o[grant] = s_ack_i;
      end else begin
         // IDLE and ABORT present an idle bus; late slave acks are dropped.
         m_ack_o = {NMASTERS{1'b0}};
      end
   end

   assign m_err_o = err;
   assign grant_o = grant;
   assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
module tb_wb_sdram_arbiter;

   logic        clk_i;
   logic        rst_i;
   logic [2:0]  m_cyc_i;
   logic [2:0]  m_stb_i;
   logic [2:0]  m_we_i;
   logic [11:0] m_sel_i;
   logic [95:0] m_adr_i;
   logic [95:0] m_dat_i;
   logic [31:0] m_dat_o;
   logic [2:0]  m_ack_o;
   logic [2:0]  m_err_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i;
   logic [1:0]  grant_o;
   logic        busy_o;

   int tests_run;
   int tests_failed;

   wb_sdram_arbiter #(
      .NMASTERS (3),
      .AW       (32),
      .DW       (32),
      .TIMEOUT  (16)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .m_cyc_i (m_cyc_i),
      .m_stb_i (m_stb_i),
      .m_we_i  (m_we_i),
      .m_sel_i (m_sel_i),
      .m_adr_i (m_adr_i),
      .m_dat_i (m_dat_i),
      .m_dat_o (m_dat_o),
      .m_ack_o (m_ack_o),
      .m_err_o (m_err_o),
      .s_cyc_o (s_cyc_o),
      .s_stb_o (s_stb_o),
      .s_we_o  (s_we_o),
      .s_sel_o (s_sel_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_dat_i (s_dat_i),
      .s_ack_i (s_ack_i),
      .grant_o (grant_o),
      .busy_o  (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Advance to 1 ns after the next rising edge.
   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset;
      rst_i   = 1'b0;
      m_cyc_i = 3'b000;
      m_stb_i = 3'b000;
      m_we_i  = 3'b000;
      m_sel_i = 12'h000;
      m_adr_i = 96'h0;
      m_dat_i = 96'h0;
      s_dat_i = 32'h0;
      s_ack_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      rst_i   = 1'b0;
      m_cyc_i = 3'b111;
      m_stb_i = 3'b111;
      s_ack_i = 1'b1;
      m_adr_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      tick();
      tick();
      tests_run++; if (s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL reset_s_cyc: got %0h want 0", s_cyc_o); end
      tests_run++; if (s_stb_o !== 1'b0) begin tests_failed++; $display("FAIL reset_s_stb: got %0h want 0", s_stb_o); end
      tests_run++; if (m_ack_o !== 3'b000) begin tests_failed++; $display("FAIL reset_ack: got %0h want 0", m_ack_o); end
      tests_run++; if (m_err_o !== 3'b000) begin tests_failed++; $display("FAIL reset_err: got %0h want 0", m_err_o); end
      tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0h want 0", busy_o); end
      tests_run++; if (grant_o !== 2'd0) begin tests_failed++; $display("FAIL reset_grant: got %0h want 0", grant_o); end
      tests_run++; if (s_adr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_s_adr: got %0h want 0", s_adr_o); end
      s_ack_i = 1'b0;
      rst_i   = 1'b1;
      #1;
      tests_run++; if (s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL release_idle_s_cyc: got %0h want 0", s_cyc_o); end
      tick();
      tests_run++; if (grant_o !== 2'd0) begin tests_failed++; $display("FAIL release_grant: got %0h want 0", grant_o); end
      tests_run++; if (s_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL release_s_cyc: got %0h want 1", s_cyc_o); end
      tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL release_busy: got %0h want 1", busy_o); end
      do_reset();
   endtask

   task automatic test_fairness;
      logic [1:0] exp_g;
      logic [2:0] exp_ack;
      do_reset();
      m_cyc_i = 3'b111;
      m_stb_i = 3'b111;
      #1;
      for (int r = 0; r < 6; r++) begin
         exp_g   = 2'(r % 3);
         exp_ack = 3'b001 << exp_g;
         tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL fair_idle_busy r%0d: got %0h want 0", r, busy_o); end
         tests_run++; if (s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL fair_idle_s_cyc r%0d: got %0h want 0", r, s_cyc_o); end
         tick();
         tests_run++; if (grant_o !== exp_g) begin tests_failed++; $display("FAIL fair_grant r%0d: got %0d want %0d", r, grant_o, exp_g); end
         tests_run++; if (s_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL fair_s_cyc r%0d: got %0h want 1", r, s_cyc_o); end
         s_ack_i = 1'b1;
         #1;
         tests_run++; if (m_ack_o !== exp_ack) begin tests_failed++; $display("FAIL fair_ack r%0d: got %0h want %0h", r, m_ack_o, exp_ack); end
         tick();
         s_ack_i          = 1'b0;
         m_cyc_i[exp_g]   = 1'b0;
         m_stb_i[exp_g]   = 1'b0;
         #1;
         tests_run++; if (s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL fair_drop_s_cyc r%0d: got %0h want 0", r, s_cyc_o); end
         tick();
         m_cyc_i[exp_g] = 1'b1;
         m_stb_i[exp_g] = 1'b1;
         #1;
      end
      do_reset();
   endtask

   task automatic test_hold;
      do_reset();
      m_cyc_i[1] = 1'b1;
      m_stb_i[1] = 1'b1;
      #1;
      tick();
      m_cyc_i[0] = 1'b1;
      m_stb_i[0] = 1'b1;
      tests_run++; if (grant_o !== 2'd1) begin tests_failed++; $display("FAIL hold_grant1: got %0d want 1", grant_o); end
      for (int b = 0; b < 8; b++) begin
         s_ack_i = 1'b1;
         #1;
         tests_run++; if (m_ack_o !== 3'b010) begin tests_failed++; $display("FAIL hold_ack beat%0d: got %0h want 2", b, m_ack_o); end
         tick();
      end
      s_ack_i    = 1'b0;
      m_cyc_i[1] = 1'b0;
      m_stb_i[1] = 1'b0;
      #1;
      tests_run++; if (m_ack_o !== 3'b000) begin tests_failed++; $display("FAIL hold_end_ack: got %0h want 0", m_ack_o); end
      tests_run++; if (s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL hold_end_s_cyc: got %0h want 0", s_cyc_o); end
      tick();
      tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL hold_idle_busy: got %0h want 0", busy_o); end
      tick();
      tests_run++; if (grant_o !== 2'd0) begin tests_failed++; $display("FAIL hold_next_grant: got %0d want 0", grant_o); end
      tests_run++; if (s_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL hold_next_s_cyc: got %0h want 1", s_cyc_o); end
      do_reset();
   endtask

   task automatic test_routing;
      do_reset();
      m_adr_i = {32'h0000_1000, 32'hAAAA_0000, 32'h0000_5555};
      m_dat_i = {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
      m_sel_i = {4'hF, 4'hC, 4'h3};
      m_we_i  = 3'b100;
      m_cyc_i = 3'b100;
      m_stb_i = 3'b100;
      #1;
      tests_run++; if (s_adr_o !== 32'h0) begin tests_failed++; $display("FAIL route_idle_adr: got %0h want 0", s_adr_o); end
      tick();
      tests_run++; if (grant_o !== 2'd2) begin tests_failed++; $display("FAIL route_grant2: got %0d want 2", grant_o); end
      tests_run++; if (s_adr_o !== 32'h0000_1000) begin tests_failed++; $display("FAIL route_adr: got %0h want 1000", s_adr_o); end
      tests_run++; if (s_dat_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL route_dat: got %0h want deadbeef", s_dat_o); end
      tests_run++; if (s_sel_o !== 4'hF) begin tests_failed++; $display("FAIL route_sel: got %0h want f", s_sel_o); end
      tests_run++; if (s_we_o !== 1'b1) begin tests_failed++; $display("FAIL route_we: got %0h want 1", s_we_o); end
      tests_run++; if (s_stb_o !== 1'b1) begin tests_failed++; $display("FAIL route_stb: got %0h want 1", s_stb_o); end
      s_ack_i = 1'b1;
      #1;
      tests_run++; if (m_ack_o !== 3'b100) begin tests_failed++; $display("FAIL route_ack2: got %0h want 4", m_ack_o); end
      tick();
      s_ack_i = 1'b0;
      m_cyc_i = 3'b000;
      m_stb_i = 3'b000;
      m_we_i  = 3'b000;
      #1;
      tick();
      m_cyc_i = 3'b001;
      m_stb_i = 3'b001;
      s_dat_i = 32'h1234_5678;
      #1;
      tests_run++; if (m_dat_o !== 32'h1234_5678) begin tests_failed++; $display("FAIL route_idle_rdata: got %0h want 12345678", m_dat_o); end
      tick();
      tests_run++; if (grant_o !== 2'd0) begin tests_failed++; $display("FAIL route_grant0: got %0d want 0", grant_o); end
      tests_run++; if (s_adr_o !== 32'h0000_5555) begin tests_failed++; $display("FAIL route_adr0: got %0h want 5555", s_adr_o); end
      tests_run++; if (s_sel_o !== 4'h3) begin tests_failed++; $display("FAIL route_sel0: got %0h want 3", s_sel_o); end
      tests_run++; if (s_we_o !== 1'b0) begin tests_failed++; $display("FAIL route_we0: got %0h want 0", s_we_o); end
      s_dat_i = 32'hCAFE_F00D;
      s_ack_i = 1'b1;
      #1;
      tests_run++; if (m_dat_o !== 32'hCAFE_F00D) begin tests_failed++; $display("FAIL route_rdata: got %0h want cafef00d", m_dat_o); end
      tests_run++; if (m_ack_o !== 3'b001) begin tests_failed++; $display("FAIL route_ack0: got %0h want 1", m_ack_o); end
      do_reset();
   endtask

   task automatic test_timeout;
      do_reset();
      m_cyc_i = 3'b010;
      m_stb_i = 3'b010;
      #1;
      tick();
      tests_run++; if (grant_o !== 2'd1) begin tests_failed++; $display("FAIL to_grant: got %0d want 1", grant_o); end
      for (int c = 1; c <= 16; c++) begin
         tests_run++; if (m_err_o !== 3'b000) begin tests_failed++; $display("FAIL to_early_err c%0d: got %0h want 0", c, m_err_o); end
         tests_run++; if (s_stb_o !== 1'b1) begin tests_failed++; $display("FAIL to_stb c%0d: got %0h want 1", c, s_stb_o); end
         tick();
      end
      tests_run++; if (m_err_o !== 3'b010) begin tests_failed++; $display("FAIL to_err: got %0h want 2", m_err_o); end
      tests_run++; if (s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL to_abort_s_cyc: got %0h want 0", s_cyc_o); end
      tests_run++; if (s_stb_o !== 1'b0) begin tests_failed++; $display("FAIL to_abort_s_stb: got %0h want 0", s_stb_o); end
      tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL to_abort_busy: got %0h want 1", busy_o); end
      s_ack_i = 1'b1;
      #1;
      tests_run++; if (m_ack_o !== 3'b000) begin tests_failed++; $display("FAIL to_late_ack: got %0h want 0", m_ack_o); end
      tick();
      tests_run++; if (m_err_o !== 3'b000) begin tests_failed++; $display("FAIL to_err_pulse_len: got %0h want 0", m_err_o); end
      tests_run++; if (m_ack_o !== 3'b000) begin tests_failed++; $display("FAIL to_late_ack2: got %0h want 0", m_ack_o); end
      tests_run++; if (busy_o !== 1'b1) begin tests_failed++; $display("FAIL to_abort_hold: got %0h want 1", busy_o); end
      s_ack_i = 1'b0;
      m_cyc_i = 3'b000;
      m_stb_i = 3'b000;
      tick();
      tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL to_release_busy: got %0h want 0", busy_o); end
      do_reset();
   endtask

   task automatic test_edge;
      do_reset();
      m_cyc_i = 3'b001;
      m_stb_i = 3'b001;
      #1;
      tick();
      for (int c = 1; c < 16; c++) begin
         tick();
      end
      s_ack_i = 1'b1;
      #1;
      tests_run++; if (m_ack_o !== 3'b001) begin tests_failed++; $display("FAIL edge_ack: got %0h want 1", m_ack_o); end
      tick();
      s_ack_i = 1'b0;
      #1;
      tests_run++; if (m_err_o !== 3'b000) begin tests_failed++; $display("FAIL edge_no_err: got %0h want 0", m_err_o); end
      tests_run++; if (s_cyc_o !== 1'b1) begin tests_failed++; $display("FAIL edge_still_granted: got %0h want 1", s_cyc_o); end
      tick();
      tests_run++; if (m_err_o !== 3'b000) begin tests_failed++; $display("FAIL edge_no_err2: got %0h want 0", m_err_o); end
      do_reset();
      // Asynchronous reset while master 2 owns the bus.
      m_adr_i = {32'h0000_2000, 32'h0, 32'h0};
      m_cyc_i = 3'b100;
      m_stb_i = 3'b100;
      #1;
      tick();
      tests_run++; if (grant_o !== 2'd2) begin tests_failed++; $display("FAIL arst_pre_grant: got %0d want 2", grant_o); end
      s_ack_i = 1'b1;
      rst_i   = 1'b0;
      #1;
      tests_run++; if (s_cyc_o !== 1'b0) begin tests_failed++; $display("FAIL arst_s_cyc: got %0h want 0", s_cyc_o); end
      tests_run++; if (s_adr_o !== 32'h0) begin tests_failed++; $display("FAIL arst_s_adr: got %0h want 0", s_adr_o); end
      tests_run++; if (m_ack_o !== 3'b000) begin tests_failed++; $display("FAIL arst_ack: got %0h want 0", m_ack_o); end
      tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL arst_busy: got %0h want 0", busy_o); end
      tests_run++; if (grant_o !== 2'd0) begin tests_failed++; $display("FAIL arst_grant: got %0d want 0", grant_o); end
      do_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_i   = 1'b0;
      m_cyc_i = 3'b000;
      m_stb_i = 3'b000;
      m_we_i  = 3'b000;
      m_sel_i = 12'h000;
      m_adr_i = 96'h0;
      m_dat_i = 96'h0;
      s_dat_i = 32'h0;
      s_ack_i = 1'b0;
      tick();
      test_reset();
      test_fairness();
      test_hold();
      test_routing();
      test_timeout();
      test_edge();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
